// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier
//   Sequential 8x8 unsigned shift-and-add multiplier. A single eight_bit_adder
//   is reused once per cycle to add the multiplicand into the upper partial
//   product. The 16-bit result appears 9 cycles after an accepted start.
//
// Ports
//   clk      in   rising-edge clock
//   rstn     in   synchronous active-low reset
//   start    in   operation request, sampled in IDLE and DONE only
//   a, b     in   8-bit unsigned multiplicand / multiplier
//   product  out  16-bit registered result, held until the next result
//   busy     out  high while the 8 iterations are running
//   done     out  one-cycle pulse when product is updated
//
// State table
//   state  | meaning
//   IDLE   | waiting for start
//   RUN    | one shift-and-add iteration per cycle, 8 in total
//   DONE   | product valid, done pulse; start here chains a new operation

module eight_bit_adder (
  output logic [7:0] sum,
  output logic       cout,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin
);
  logic [8:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < 8; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[8];
  end
endmodule

module shift_add_multiplier (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] product,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  m_q, m_d;
  logic [7:0]  acc_q, acc_d;
  logic [7:0]  q_q, q_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] product_q, product_d;

  logic [7:0]  add_sum;
  logic        add_cout;

  eight_bit_adder u_adder (
    .sum  (add_sum),
    .cout (add_cout),
    .a    (acc_q),
    .b    (m_q),
    .cin  (1'b0)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      m_q       <= '0;
      acc_q     <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_q     <= acc_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_d     = acc_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          m_d     = a;
          q_d     = b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        // The adder carry becomes the new acc[7], so the 9-bit partial sum
        // is never truncated.
        if (q_q[0]) begin
          {acc_d, q_d} = {add_cout, add_sum, q_q[7:1]};
        end else begin
          {acc_d, q_d} = {1'b0, acc_q, q_q[7:1]};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d   = S_DONE;
          product_d = {acc_d, q_d};
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign product = product_q;
  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
endmodule

// File: tb/tb_shift_add_multiplier.sv
module tb_shift_add_multiplier;
  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] product;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .a       (a),
    .b       (b),
    .product (product),
    .busy    (busy),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Called at the negedge right after the accepting edge E0 (cycle 1).
  // Returns the number of negedge samples until done is seen, capped at 30.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    rstn = 1'b0; start = 1'b1; a = 8'd9; b = 8'd9;
    repeat (2) @(negedge clk);
    checks++;
    if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold got product=%h busy=%b done=%b want 0000/0/0", product, busy, done);
    end
    rstn = 1'b1; start = 1'b0;
    @(negedge clk);
    checks++;
    if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got product=%h busy=%b done=%b want 0000/0/0", product, busy, done);
    end
  endtask

  task automatic test_basic;
    int cyc;
    a = 8'd13; b = 8'd11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b want 1", busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 9) begin
      errors++;
      $display("FAIL basic_latency got %0d want 9", cyc);
    end
    checks++;
    if (product !== 16'h008F || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_product got %h busy=%b want 008f busy=0", product, busy);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_single_pulse got done=%b busy=%b want 0/0", done, busy);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (product !== 16'h008F) begin
      errors++;
      $display("FAIL basic_hold_idle got %h want 008f", product);
    end
  endtask

  task automatic test_max;
    int cyc;
    a = 8'd255; b = 8'd255; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (product !== 16'h008F) begin
      errors++;
      $display("FAIL max_hold_during_run got %h want 008f", product);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 9 || product !== 16'hFE01) begin
      errors++;
      $display("FAIL max_product got %h after %0d want fe01 after 9", product, cyc);
    end
    @(negedge clk);
  endtask

  task automatic test_zero;
    logic [7:0] av [2];
    logic [7:0] bv [2];
    int cyc;
    av[0] = 8'd0;   bv[0] = 8'd200;
    av[1] = 8'd200; bv[1] = 8'd0;
    for (int i = 0; i < 2; i++) begin
      a = av[i]; b = bv[i]; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(cyc);
      checks++;
      if (cyc != 9 || product !== 16'h0000) begin
        errors++;
        $display("FAIL zero_%0d got %h after %0d want 0000 after 9", i, product, cyc);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    int pulses;
    a = 8'd3; b = 8'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    a = 8'd7; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 4;
    while (done !== 1'b1 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (cyc != 9 || product !== 16'h000F) begin
      errors++;
      $display("FAIL ignore_product got %h after %0d want 000f after 9", product, cyc);
    end
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ignore_extra_done got %0d pulses busy=%b want 0 pulses busy=0", pulses, busy);
    end
  endtask

  task automatic test_back_to_back;
    int cyc;
    a = 8'd16; b = 8'd16; start = 1'b1;
    @(negedge clk);
    wait_done(cyc);
    checks++;
    if (cyc != 9 || product !== 16'h0100) begin
      errors++;
      $display("FAIL b2b_first got %h after %0d want 0100 after 9", product, cyc);
    end
    a = 8'd2; b = 8'd128;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart got done=%b busy=%b want 0/1", done, busy);
    end
    wait_done(cyc);
    checks++;
    if (cyc != 9 || product !== 16'h0100) begin
      errors++;
      $display("FAIL b2b_second got %h after %0d want 0100 after 9", product, cyc);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_reset_midrun;
    int cyc;
    int pulses;
    a = 8'd100; b = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    checks++;
    if (product !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrun_clear got product=%h busy=%b done=%b want 0000/0/0", product, busy, done);
    end
    rstn = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL midrun_no_done got %0d active cycles want 0", pulses);
    end
    a = 8'd100; b = 8'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc != 9 || product !== 16'h2710) begin
      errors++;
      $display("FAIL midrun_restart got %h after %0d want 2710 after 9", product, cyc);
    end
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; a = '0; b = '0;
    test_reset();
    test_basic();
    test_max();
    test_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
